// File: rtl/ffe_sample_loader.sv
// FFE sample loader: buffers upstream samples and strobes them into the FFE
// one at a time. Each load waits for the FFE's data_valid rising edge, keeps a
// minimum load-to-load spacing, and flags an FFE that never answers.
module ffe_sample_loader #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_GAP    = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          ffe_load,
    output logic [DATA_WIDTH-1:0]         ffe_data,
    input  logic                          ffe_valid,
    output logic                          busy,
    output logic                          timeout_pulse,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   done_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned GAP_W = $clog2(MIN_GAP);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Sample buffer and extra-bit pointers (occupancy = wr - rd)
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [LVL_W-1:0]      wr_ptr_q;
    logic [LVL_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_c;
    logic                  full_c;
    logic                  empty_c;
    logic                  push_c;
    logic                  pop_c;

    state_e                state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  load_q, load_d;
    logic                  tpulse_q, tpulse_d;
    logic                  terr_q, terr_d;
    logic                  ffe_valid_q;
    logic                  vedge_c;

    assign level_c = wr_ptr_q - rd_ptr_q;
    assign full_c  = (level_c == LVL_W'(FIFO_DEPTH));
    assign empty_c = (level_c == '0);
    // No fall-through: a full buffer refuses even when popping this cycle
    assign s_ready = !full_c && !rst;
    assign push_c  = s_valid && s_ready;
    assign vedge_c = ffe_valid && !ffe_valid_q;

    // Buffer storage write
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= s_data;
        end
    end

    // Buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + LVL_W'(1);
        end
    end

    // Next state, spacing/timeout counters and FFE-side outputs
    always_comb begin
        state_d  = state_q;
        pop_c    = 1'b0;
        gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        to_cnt_d = to_cnt_q;
        done_d   = done_q;
        data_d   = data_q;
        load_d   = 1'b0;
        tpulse_d = 1'b0;
        terr_d   = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c && (gap_q == '0)) begin
                    state_d = ST_LOAD;
                    pop_c   = 1'b1;
                    data_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
                    load_d  = 1'b1;
                    gap_d   = GAP_W'(MIN_GAP - 1);
                end
            end
            ST_LOAD: begin
                state_d  = ST_WAIT;
                to_cnt_d = '0;
            end
            ST_WAIT: begin
                // An edge landing on the last timeout cycle still counts as an answer
                if (vedge_c) begin
                    done_d  = done_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    tpulse_d = 1'b1;
                    terr_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            to_cnt_q    <= '0;
            done_q      <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            tpulse_q    <= 1'b0;
            terr_q      <= 1'b0;
            ffe_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            data_q      <= data_d;
            load_q      <= load_d;
            tpulse_q    <= tpulse_d;
            terr_q      <= terr_d;
            ffe_valid_q <= ffe_valid;
        end
    end

    assign ffe_load      = load_q;
    assign ffe_data      = data_q;
    assign timeout_pulse = tpulse_q;
    assign timeout_err   = terr_q;
    assign done_count    = done_q;
    assign fifo_level    = level_c;
    assign busy          = (state_q != ST_IDLE) || !empty_c;

endmodule

// File: tb/tb_ffe_sample_loader.sv
// Directed bench for ffe_sample_loader with a hand-driven FFE response.
module tb_ffe_sample_loader;

    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          ffe_load;
    logic [DW-1:0] ffe_data;
    logic          ffe_valid;
    logic          busy;
    logic          timeout_pulse;
    logic          timeout_err;
    logic [2:0]    fifo_level;
    logic [15:0]   done_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] load_data[$];
    int            load_cyc[$];

    ffe_sample_loader #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4),
        .MIN_GAP   (4),
        .TIMEOUT   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .ffe_load     (ffe_load),
        .ffe_data     (ffe_data),
        .ffe_valid    (ffe_valid),
        .busy         (busy),
        .timeout_pulse(timeout_pulse),
        .timeout_err  (timeout_err),
        .fifo_level   (fifo_level),
        .done_count   (done_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every load strobe with its data and cycle number
    always @(negedge clk) begin
        if (ffe_load === 1'b1) begin
            load_data.push_back(ffe_data);
            load_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 100; i++) begin
            if (s_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_accept value=%h s_ready stuck at %b", v, s_ready);
        end
    endtask

    task automatic wait_load(input int max_cyc, output logic ok, output logic [DW-1:0] d,
                             output int n);
        ok = 1'b0;
        d  = '0;
        n  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            n++;
            if (ffe_load) begin
                ok = 1'b1;
                d  = ffe_data;
                break;
            end
        end
    endtask

    // FFE answers: data_valid high for one cycle, d cycles after the load cycle
    task automatic respond(input int d);
        repeat (d) tick();
        ffe_valid = 1'b1;
        tick();
        ffe_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; ffe_valid = 1'b0;
        tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (ffe_load !== 1'b0) begin bad++; $display("FAIL rst_load got=%b exp=0", ffe_load); end
        total++; if (ffe_data !== 12'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", ffe_data); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        total++; if (done_count !== 16'd0) begin bad++; $display("FAIL rst_done got=%0d exp=0", done_count); end
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_single();
        logic ok; logic [DW-1:0] d; int n; int base;
        base = load_data.size();
        push(12'h7FF);
        wait_load(10, ok, d, n);
        total++; if (!ok || n != 1) begin bad++; $display("FAIL single_latency got ok=%b n=%0d exp n=1", ok, n); end
        total++; if (d !== 12'h7FF) begin bad++; $display("FAIL single_data got=%h exp=7ff", d); end
        respond(6);
        total++; if (done_count !== 16'd1) begin bad++; $display("FAIL single_done got=%0d exp=1", done_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
        repeat (8) tick();
        total++; if (load_data.size() - base != 1) begin bad++; $display("FAIL single_load_count got=%0d exp=1", load_data.size() - base); end
    endtask

    task automatic test_fill_backpressure();
        logic ok; logic [DW-1:0] d; int n; int base;
        logic [DW-1:0] exp_v [5];
        exp_v[0] = 12'hFFF; exp_v[1] = 12'h800; exp_v[2] = 12'h003;
        exp_v[3] = 12'h064; exp_v[4] = 12'hFFB;
        base = load_data.size();
        for (int i = 0; i < 5; i++) push(exp_v[i]);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", fifo_level); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", s_ready); end
        // Release the stalled first transaction by hand
        ffe_valid = 1'b1;
        tick();
        ffe_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_load(20, ok, d, n);
            total++; if (!ok) begin bad++; $display("FAIL fill_load_wait idx=%0d got none exp load", i + 1); end
            respond(2);
        end
        total++; if (done_count !== 16'd6) begin bad++; $display("FAIL fill_done got=%0d exp=6", done_count); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL fill_terr got=%b exp=0", timeout_err); end
        total++;
        if (load_data.size() - base != 5) begin
            bad++; $display("FAIL fill_load_count got=%0d exp=5", load_data.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (load_data[base + i] !== exp_v[i]) begin
                    bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, load_data[base + i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_gap();
        logic ok; logic [DW-1:0] d; int n; int base;
        base = load_data.size();
        for (int i = 0; i < 5; i++) push(DW'(16 + i));
        ffe_valid = 1'b1;
        tick();
        ffe_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_load(20, ok, d, n);
            total++; if (!ok) begin bad++; $display("FAIL gap_load_wait idx=%0d got none exp load", i + 1); end
            respond(1);
        end
        total++; if (done_count !== 16'd11) begin bad++; $display("FAIL gap_done got=%0d exp=11", done_count); end
        total++;
        if (load_data.size() - base != 5) begin
            bad++; $display("FAIL gap_load_count got=%0d exp=5", load_data.size() - base);
        end else begin
            for (int i = 2; i < 5; i++) begin
                total++;
                if (load_cyc[base + i] - load_cyc[base + i - 1] != 4) begin
                    bad++; $display("FAIL gap_spacing idx=%0d got=%0d exp=4", i, load_cyc[base + i] - load_cyc[base + i - 1]);
                end
            end
            total++;
            if (load_data[base + 4] !== 12'h014) begin
                bad++; $display("FAIL gap_last_data got=%h exp=014", load_data[base + 4]);
            end
        end
    endtask

    task automatic test_timeout();
        logic ok; logic [DW-1:0] d; int n;
        // Edge on the final timeout cycle wins
        push(12'h0A1);
        wait_load(20, ok, d, n);
        total++; if (!ok) begin bad++; $display("FAIL race_load got none exp load"); end
        repeat (64) tick();
        ffe_valid = 1'b1;
        tick();
        ffe_valid = 1'b0;
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL race_pulse got=%b exp=0", timeout_pulse); end
        total++; if (done_count !== 16'd12) begin bad++; $display("FAIL race_done got=%0d exp=12", done_count); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL race_terr got=%b exp=0", timeout_err); end
        // FFE never answers
        push(12'h0B2);
        wait_load(20, ok, d, n);
        total++; if (!ok) begin bad++; $display("FAIL to_load got none exp load"); end
        tick();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (timeout_pulse) break;
        end
        total++; if (n != 64) begin bad++; $display("FAIL to_delay got=%0d exp=64", n); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_terr got=%b exp=1", timeout_err); end
        total++; if (done_count !== 16'd12) begin bad++; $display("FAIL to_done got=%0d exp=12", done_count); end
        tick();
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL to_pulse_width got=%b exp=0", timeout_pulse); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
        push(12'h0C3);
        wait_load(20, ok, d, n);
        total++; if (!ok || d !== 12'h0C3) begin bad++; $display("FAIL to_next_load got ok=%b data=%h exp=0c3", ok, d); end
        respond(3);
        total++; if (done_count !== 16'd13) begin bad++; $display("FAIL to_next_done got=%0d exp=13", done_count); end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        push(12'h111);
        push(12'h222);
        push(12'h333);
        total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL mid_level_pre got=%0d exp=2", fifo_level); end
        rst = 1'b1;
        tick();
        base = load_data.size();
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL mid_terr got=%b exp=0", timeout_err); end
        total++; if (done_count !== 16'd0) begin bad++; $display("FAIL mid_done got=%0d exp=0", done_count); end
        total++; if (ffe_data !== 12'h000) begin bad++; $display("FAIL mid_data got=%h exp=000", ffe_data); end
        rst = 1'b0;
        repeat (20) tick();
        total++; if (load_data.size() != base) begin bad++; $display("FAIL mid_no_load got=%0d exp=0", load_data.size() - base); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", s_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_gap();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
